snake_state_map: RTL and testbench
==================================

// Module: snake_state_map
// PURPOSE
//  Holds live game state (snake segments, apple, run/over status) and answers the image
//  generator's per-cell queries: given x,y, it returns snakeHead/snakeBody/apple/border
//  combinationally. It sits directly upstream of image_generator, advances one cell per
//  move_tick, grows on eating an apple and relocates the apple pseudo-randomly.
// PARAMETERS
//  MAX_LEN   50  maximum snake length in segments; must be < 140 (playfield cells)
//  START_X   4   head x after reset/restart
//  START_Y   4   head y after reset/restart
//  APPLE_X0  7   apple x after reset/restart
//  APPLE_Y0  4   apple y after reset/restart
//  LFSR_SEED 8'hA5  apple LFSR reset value; must be non-zero
// PORTS
//  clk        in   1  system clock
//  nrst       in   1  asynchronous active-low reset
//  restart    in   1  synchronous re-init of game state; highest priority, any state
//  move_tick  in   1  one-cycle pulse: advance snake one cell
//  dir_valid  in   1  one-cycle pulse: dir holds a new direction request
//  dir        in   2  00 right(x+1), 01 left(x-1), 10 up(y-1), 11 down(y+1)
//  x, y       in   4  query cell from image_generator
//  snakeHead  out  1  comb: (x,y) == seg[0]
//  snakeBody  out  1  comb: (x,y) == seg[i] for any 1 <= i < len
//  apple      out  1  comb: (x,y) == apple position; forced 0 while in RELOC
//  border     out 1  comb: x==0 | x==15 | y==0 | y==11
//  GameOver   out  1  registered: high in GAMEOVER state
//  length     out  6  registered: current len, 1..MAX_LEN
//  ate        out  1  registered: one-cycle pulse on the move that eats the apple
// BEHAVIOUR
//  Grid 16x12; playfield is x 1..14, y 1..10. seg[0] is the head.
//  Reset (async) and restart (sync) load the same values: state IDLE, seg[0]=(START_X,START_Y).
//  Also: len=1, apple=(APPLE_X0,APPLE_Y0), cur_dir=applied_dir=right, GameOver=0, ate=0.
//  The LFSR loads LFSR_SEED on nrst only; restart does not reload it.
//  All seg[] entries clear to (0,0) on nrst. restart takes priority over move_tick/dir_valid.
//  FSM IDLE -> RUN on first dir_valid (dir latched); move_tick is ignored in IDLE.
//  dir_valid in IDLE/RUN/RELOC: the request is dropped if it is the reverse of applied_dir.
//   applied_dir is the direction used on the last actual move, not the pending one.
//   Otherwise cur_dir <= dir; the latest request before a tick wins.
//  RUN, on move_tick: nxt = seg[0] stepped by cur_dir (4-bit arithmetic, no wrap needed).
//   grow = (nxt == apple) && (len < MAX_LEN).
//   Collision if nxt is on the border, or nxt == seg[i] for 1 <= i <= len-2.
//    When grow=1 the collision range also includes i = len-1; the tail cell stays occupied.
//   On collision: go to GAMEOVER; seg/len/apple unchanged.
//   Else: seg[i] <= seg[i-1] for all i, seg[0] <= nxt, applied_dir <= cur_dir.
//   If nxt == apple: ate=1 for one cycle, len += grow, go to RELOC.
//    At len == MAX_LEN the snake still eats, ate pulses, and len saturates.
//  RELOC: LFSR (x^8+x^6+x^5+x^4+1, Fibonacci) advances every cycle.
//   Candidate = (lfsr[3:0], lfsr[7:4]).
//   Accept if inside the playfield and different from every live segment (i < len).
//   On accept: apple <= candidate, back to RUN.
//   Maximal-length LFSR plus MAX_LEN < 140 means an accept within 255 cycles.
//   move_tick in RELOC is dropped.
//  GAMEOVER: all state frozen, queries keep reflecting the frozen board.
//   move_tick and dir_valid are ignored; only restart or nrst leaves.
//  Query outputs are purely combinational from x,y and registered state; zero latency.
//  Entries i >= len never assert snakeBody.
// STRUCTURE
//  snake_pkg: dir_t enum (RIGHT/LEFT/UP/DOWN), coord_t struct {x[3:0], y[3:0]}.
//   Also GRID_W=16, GRID_H=12 and the playfield bounds.
//   image_generator shares the same package.
//  Sub-module apple_lfsr: 8-bit LFSR with seed parameter and step enable.
//   Outputs the candidate coord_t.
//  Top level: FSM, segment shift array, MAX_LEN-wide parallel comparators.
// TESTING
//  1 Reset -> query (4,4) snakeHead=1, (7,4) apple=1, (0,5) border=1; length=1, GameOver=0.
//  2 dir_valid right, 3 move_ticks -> 3rd tick ate=1 for 1 cycle; length=2,
//    head (7,4), body (6,4); within 255 cycles apple lands inside the playfield,
//    not on (7,4) or (6,4).
//  3 Moving right, dir_valid left then move_tick -> request ignored; head x+1, y unchanged.
//  4 From (4,4), dir up, 4 ticks -> head (4,1) after the 3rd tick.
//    4th tick: GameOver=1, head stays (4,1); further ticks change nothing.
//  5 Bench scans x,y to find the apple and steers to eat 4 apples (len=5).
//    Then down-left-up turns -> head enters own body; GameOver=1, length stays 5.
//  6 restart in GAMEOVER and mid-RELOC -> state returns to test 1 values in 1 cycle.
//    Next first apple relocation yields a different cell than after nrst.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and grid geometry for the snake game datapath and image generator.
package snake_pkg;

    typedef enum logic [1:0] {
        RIGHT = 2'b00,
        LEFT  = 2'b01,
        UP    = 2'b10,
        DOWN  = 2'b11
    } dir_t;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } coord_t;

    localparam int unsigned GRID_W = 16;
    localparam int unsigned GRID_H = 12;

    localparam logic [3:0] BORDER_X_MAX = 4'(GRID_W - 1);
    localparam logic [3:0] BORDER_Y_MAX = 4'(GRID_H - 1);
    localparam logic [3:0] PF_X_MIN     = 4'd1;
    localparam logic [3:0] PF_X_MAX     = 4'(GRID_W - 2);
    localparam logic [3:0] PF_Y_MIN     = 4'd1;
    localparam logic [3:0] PF_Y_MAX     = 4'(GRID_H - 2);

    function automatic coord_t step_coord(input coord_t c, input dir_t d);
        coord_t r;
        r = c;
        case (d)
            RIGHT:   r.x = c.x + 4'd1;
            LEFT:    r.x = c.x - 4'd1;
            UP:      r.y = c.y - 4'd1;
            default: r.y = c.y + 4'd1;
        endcase
        return r;
    endfunction

    function automatic logic is_border(input logic [3:0] cx, input logic [3:0] cy);
        return (cx == 4'd0) || (cx == BORDER_X_MAX) || (cy == 4'd0) || (cy == BORDER_Y_MAX);
    endfunction

    function automatic logic in_playfield(input coord_t c);
        return (c.x >= PF_X_MIN) && (c.x <= PF_X_MAX) && (c.y >= PF_Y_MIN) && (c.y <= PF_Y_MAX);
    endfunction

    // Opposite directions differ only in bit 0 with this encoding.
    function automatic logic is_reverse(input dir_t a, input dir_t b);
        return (a ^ b) == 2'b01;
    endfunction

endpackage

// File: rtl/apple_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) producing apple placement candidates.
module apple_lfsr
    import snake_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic   clk,
    input  logic   nrst,
    input  logic   step,
    output coord_t cand
);

    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lfsr <= SEED;
        end else if (step) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign cand = {lfsr[3:0], lfsr[7:4]};

endmodule

// File: rtl/snake_state_map.sv
// Live snake game state with zero-latency per-cell queries for the image generator.
module snake_state_map
    import snake_pkg::*;
#(
    parameter int unsigned MAX_LEN   = 50,
    parameter int unsigned START_X   = 4,
    parameter int unsigned START_Y   = 4,
    parameter int unsigned APPLE_X0  = 7,
    parameter int unsigned APPLE_Y0  = 4,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       restart,
    input  logic       move_tick,
    input  logic       dir_valid,
    input  logic [1:0] dir,
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic       snakeHead,
    output logic       snakeBody,
    output logic       apple,
    output logic       border,
    output logic       GameOver,
    output logic [5:0] length,
    output logic       ate
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_RELOC = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam coord_t     START_POS  = {4'(START_X), 4'(START_Y)};
    localparam coord_t     APPLE_POS0 = {4'(APPLE_X0), 4'(APPLE_Y0)};
    localparam logic [5:0] MAX_LEN_W  = 6'(MAX_LEN);

    logic [1:0]  state;
    coord_t      seg [MAX_LEN];
    logic [5:0]  len;
    logic [31:0] len_w;
    coord_t      apple_pos;
    dir_t        cur_dir;
    dir_t        applied_dir;
    coord_t      nxt;
    coord_t      cand;
    coord_t      query;
    logic        eat;
    logic        grow;
    logic        collide;
    logic        cand_ok;
    logic        dir_ok;
    logic        try_move;
    logic        advance;

    apple_lfsr #(.SEED(LFSR_SEED)) u_apple_lfsr (
        .clk  (clk),
        .nrst (nrst),
        .step (state == ST_RELOC),
        .cand (cand)
    );

    assign len_w    = 32'(len);
    assign nxt      = step_coord(seg[0], cur_dir);
    assign eat      = (nxt == apple_pos);
    assign grow     = eat && (len < MAX_LEN_W);
    assign dir_ok   = dir_valid && !is_reverse(dir_t'(dir), applied_dir);
    assign try_move = (state == ST_RUN) && move_tick;
    assign advance  = try_move && !collide;

    // The tail vacates its cell on a plain move, but stays put when the snake grows.
    always_comb begin
        collide = is_border(nxt.x, nxt.y);
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
            if ((seg[i] == nxt) && ((i + 2 <= len_w) || (grow && (i + 1 == len_w)))) begin
                collide = 1'b1;
            end
        end
    end

    always_comb begin
        cand_ok = in_playfield(cand);
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if ((i < len_w) && (seg[i] == cand)) begin
                cand_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= ST_IDLE;
            len         <= 6'd1;
            apple_pos   <= APPLE_POS0;
            cur_dir     <= RIGHT;
            applied_dir <= RIGHT;
            GameOver    <= 1'b0;
            ate         <= 1'b0;
        end else if (restart) begin
            state       <= ST_IDLE;
            len         <= 6'd1;
            apple_pos   <= APPLE_POS0;
            cur_dir     <= RIGHT;
            applied_dir <= RIGHT;
            GameOver    <= 1'b0;
            ate         <= 1'b0;
        end else begin
            ate <= 1'b0;
            if (dir_ok && (state != ST_OVER)) begin
                cur_dir <= dir_t'(dir);
            end
            case (state)
                ST_IDLE: begin
                    if (dir_valid) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (try_move && collide) begin
                        state    <= ST_OVER;
                        GameOver <= 1'b1;
                    end else if (advance) begin
                        applied_dir <= cur_dir;
                        if (eat) begin
                            ate   <= 1'b1;
                            state <= ST_RELOC;
                            if (grow) begin
                                len <= len + 6'd1;
                            end
                        end
                    end
                end
                ST_RELOC: begin
                    if (cand_ok) begin
                        apple_pos <= cand;
                        state     <= ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg[i] <= '0;
            end
            seg[0] <= START_POS;
        end else if (restart) begin
            seg[0] <= START_POS;
        end else if (advance) begin
            for (int unsigned i = 1; i < MAX_LEN; i++) begin
                seg[i] <= seg[i-1];
            end
            seg[0] <= nxt;
        end
    end

    assign query     = {x, y};
    assign snakeHead = (seg[0] == query);
    assign apple     = (apple_pos == query) && (state != ST_RELOC);
    assign border    = is_border(x, y);
    assign length    = len;

    always_comb begin
        snakeBody = 1'b0;
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
            if ((i < len_w) && (seg[i] == query)) begin
                snakeBody = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snake_state_map.sv
// Directed bench for snake_state_map: reset, movement, eating, relocation, collisions, restart.
module tb_snake_state_map;
    import snake_pkg::*;

    logic       tb_clk = 1'b0;
    logic       nrst;
    logic       restart;
    logic       move_tick;
    logic       dir_valid;
    logic [1:0] dir;
    logic [3:0] x;
    logic [3:0] y;
    logic       snakeHead;
    logic       snakeBody;
    logic       apple;
    logic       border;
    logic       GameOver;
    logic [5:0] length;
    logic       ate;

    int checks = 0;
    int errors = 0;

    always #5 tb_clk = ~tb_clk;

    snake_state_map dut (
        .clk       (tb_clk),
        .nrst      (nrst),
        .restart   (restart),
        .move_tick (move_tick),
        .dir_valid (dir_valid),
        .dir       (dir),
        .x         (x),
        .y         (y),
        .snakeHead (snakeHead),
        .snakeBody (snakeBody),
        .apple     (apple),
        .border    (border),
        .GameOver  (GameOver),
        .length    (length),
        .ate       (ate)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic pulse_dir(input logic [1:0] d);
        dir       = d;
        dir_valid = 1'b1;
        cyc();
        dir_valid = 1'b0;
    endtask

    task automatic tick();
        move_tick = 1'b1;
        cyc();
        move_tick = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        cyc();
        restart = 1'b0;
    endtask

    task automatic query(input int qx, input int qy);
        x = 4'(qx);
        y = 4'(qy);
        #1;
    endtask

    task automatic find_apple(output int cnt, output int fx, output int fy);
        cnt = 0;
        fx  = -1;
        fy  = -1;
        for (int xx = 0; xx < 16; xx++) begin
            for (int yy = 0; yy < 12; yy++) begin
                query(xx, yy);
                if (apple) begin
                    cnt++;
                    fx = xx;
                    fy = yy;
                end
            end
        end
    endtask

    task automatic check_reset(input string p);
        check({p, "_len"}, length, 1);
        check({p, "_gameover"}, GameOver, 0);
        check({p, "_ate"}, ate, 0);
        query(4, 4);
        check({p, "_head_4_4"}, snakeHead, 1);
        query(7, 4);
        check({p, "_apple_7_4"}, apple, 1);
        check({p, "_nohead_7_4"}, snakeHead, 0);
        query(5, 4);
        check({p, "_nobody_5_4"}, snakeBody, 0);
    endtask

    task automatic step_xy(input logic [1:0] d, inout int sx, inout int sy);
        case (d)
            2'b00:   sx = sx + 1;
            2'b01:   sx = sx - 1;
            2'b10:   sy = sy - 1;
            default: sy = sy + 1;
        endcase
    endtask

    function automatic logic inpf(input int cx, input int cy);
        return (cx >= 1) && (cx <= 14) && (cy >= 1) && (cy <= 10);
    endfunction

    // Greedy steering; for a snake of length <= 4 only a reversal can block the wanted move.
    function automatic logic [1:0] choose(input int hx, input int hy, input int ax, input int ay,
                                          input logic [1:0] last);
        logic [1:0] w;
        if (ax != hx) begin
            w = (ax > hx) ? 2'b00 : 2'b01;
            if (w != (last ^ 2'b01)) return w;
        end
        if (ay != hy) begin
            w = (ay > hy) ? 2'b11 : 2'b10;
            if (w != (last ^ 2'b01)) return w;
        end
        if (last[1] == 1'b0) return (hy < 10) ? 2'b11 : 2'b10;
        return (hx < 14) ? 2'b00 : 2'b01;
    endfunction

    int         cnt, ax, ay, hx, hy, exp_len, moves, c1x, c1y, c2x, c2y, first_ax, first_ay;
    int         hist_x [5];
    int         hist_y [5];
    logic [1:0] last_dir, d, pdir, rev_d;
    logic [1:0] p_opt [2];
    logic       ok;

    initial begin
        nrst      = 1'b0;
        restart   = 1'b0;
        move_tick = 1'b0;
        dir_valid = 1'b0;
        dir       = 2'b00;
        x         = 4'd0;
        y         = 4'd0;
        repeat (3) @(posedge tb_clk);
        #1;
        nrst = 1'b1;
        cyc();

        // Test 1: reset state and border decode
        check_reset("t1");
        query(0, 5);
        check("t1_border_0_5", border, 1);
        query(15, 11);
        check("t1_border_15_11", border, 1);
        query(5, 5);
        check("t1_border_5_5", border, 0);
        query(14, 10);
        check("t1_border_14_10", border, 0);

        // Test 2: three moves right eat the apple at (7,4)
        pulse_dir(RIGHT);
        tick();
        check("t2_ate_tick1", ate, 0);
        query(5, 4);
        check("t2_head_5_4", snakeHead, 1);
        tick();
        tick();
        check("t2_ate_tick3", ate, 1);
        cyc();
        check("t2_ate_one_cycle", ate, 0);
        check("t2_len", length, 2);
        query(7, 4);
        check("t2_head_7_4", snakeHead, 1);
        query(6, 4);
        check("t2_body_6_4", snakeBody, 1);
        query(5, 4);
        check("t2_nobody_5_4", snakeBody, 0);
        repeat (260) cyc();
        find_apple(cnt, ax, ay);
        first_ax = ax;
        first_ay = ay;
        check("t2_apple_count", cnt, 1);
        check("t2_apple_in_pf", inpf(ax, ay), 1);
        check("t2_apple_not_head", (ax == 7 && ay == 4), 0);
        check("t2_apple_not_body", (ax == 6 && ay == 4), 0);
        check("t2_apple_x_seed", ax, 5);
        check("t2_apple_y_seed", ay, 10);

        // Test 3: reversal request dropped; latest valid request wins
        pulse_dir(LEFT);
        tick();
        query(8, 4);
        check("t3_head_8_4", snakeHead, 1);
        query(7, 4);
        check("t3_body_7_4", snakeBody, 1);
        query(6, 4);
        check("t3_nohead_6_4", snakeHead, 0);
        check("t3_len", length, 2);
        pulse_dir(UP);
        pulse_dir(RIGHT);
        tick();
        query(9, 4);
        check("t3_head_9_4", snakeHead, 1);

        // Test 4: run up into the top border
        do_restart();
        check_reset("t4_rst");
        pulse_dir(UP);
        tick();
        tick();
        tick();
        query(4, 1);
        check("t4_head_4_1", snakeHead, 1);
        check("t4_no_over_yet", GameOver, 0);
        tick();
        check("t4_gameover", GameOver, 1);
        query(4, 1);
        check("t4_head_frozen", snakeHead, 1);
        check("t4_len_frozen", length, 1);
        tick();
        pulse_dir(LEFT);
        tick();
        query(4, 1);
        check("t4_head_still", snakeHead, 1);
        query(3, 1);
        check("t4_no_move_left", snakeHead, 0);
        check("t4_gameover_still", GameOver, 1);

        // Test 5: eat four apples, then turn into own body
        do_restart();
        check_reset("t5_rst");
        hx       = 4;
        hy       = 4;
        ax       = 7;
        ay       = 4;
        exp_len  = 1;
        last_dir = RIGHT;
        for (int i = 0; i < 5; i++) begin
            hist_x[i] = -1;
            hist_y[i] = -1;
        end
        hist_x[0] = 4;
        hist_y[0] = 4;
        for (int n = 0; n < 4; n++) begin
            moves = 0;
            while (!(hx == ax && hy == ay) && moves < 60) begin
                d = choose(hx, hy, ax, ay, last_dir);
                pulse_dir(d);
                tick();
                moves++;
                step_xy(d, hx, hy);
                last_dir = d;
                for (int i = 4; i > 0; i--) begin
                    hist_x[i] = hist_x[i-1];
                    hist_y[i] = hist_y[i-1];
                end
                hist_x[0] = hx;
                hist_y[0] = hy;
                if (hx == ax && hy == ay) begin
                    check("t5_ate", ate, 1);
                    exp_len++;
                    check("t5_len_grow", length, 32'(exp_len));
                end
                query(hx, hy);
                check("t5_head_track", snakeHead, 1);
            end
            check("t5_nav_within_budget", (moves < 60), 1);
            repeat (260) cyc();
            find_apple(cnt, ax, ay);
            check("t5_apple_count", cnt, 1);
        end
        check("t5_len5", length, 5);
        check("t5_alive", GameOver, 0);

        rev_d    = last_dir ^ 2'b01;
        p_opt[0] = (last_dir[1] == 1'b0) ? 2'b11 : 2'b00;
        p_opt[1] = p_opt[0] ^ 2'b01;
        pdir     = p_opt[0];
        for (int k = 1; k >= 0; k--) begin
            c1x = hx;
            c1y = hy;
            step_xy(p_opt[k], c1x, c1y);
            c2x = c1x;
            c2y = c1y;
            step_xy(rev_d, c2x, c2y);
            ok = inpf(c1x, c1y) && inpf(c2x, c2y) &&
                 !(c1x == ax && c1y == ay) && !(c2x == ax && c2y == ay);
            for (int i = 0; i < 5; i++) begin
                if ((hist_x[i] == c1x && hist_y[i] == c1y) ||
                    (hist_x[i] == c2x && hist_y[i] == c2y)) ok = 1'b0;
            end
            if (ok) pdir = p_opt[k];
        end
        pulse_dir(pdir);
        tick();
        step_xy(pdir, hx, hy);
        check("t5_turn1_alive", GameOver, 0);
        query(hx, hy);
        check("t5_turn1_head", snakeHead, 1);
        pulse_dir(rev_d);
        tick();
        step_xy(rev_d, hx, hy);
        check("t5_turn2_alive", GameOver, 0);
        query(hx, hy);
        check("t5_turn2_head", snakeHead, 1);
        pulse_dir(pdir ^ 2'b01);
        tick();
        check("t5_self_hit_gameover", GameOver, 1);
        check("t5_self_hit_len", length, 5);
        query(hx, hy);
        check("t5_self_hit_head_frozen", snakeHead, 1);
        tick();
        check("t5_over_len_frozen", length, 5);

        // Test 6: restart from GAMEOVER and mid-RELOC
        do_restart();
        check_reset("t6_over");
        query(hx, hy);
        check("t6_old_body_gone", snakeBody, 0);
        pulse_dir(RIGHT);
        tick();
        tick();
        tick();
        check("t6_ate", ate, 1);
        do_restart();
        check_reset("t6_reloc");
        pulse_dir(RIGHT);
        tick();
        tick();
        tick();
        check("t6_ate_again", ate, 1);
        repeat (260) cyc();
        find_apple(cnt, ax, ay);
        check("t6_apple_count", cnt, 1);
        check("t6_apple_in_pf", inpf(ax, ay), 1);
        check("t6_apple_differs", (ax == first_ax && ay == first_ay), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
